// File: rtl/apu_pkg.sv
// Shared APU constants: length-counter widths and the 32-entry
// length table (counts reached after a length-register write).
package apu_pkg;

    localparam int LC_W     = 8;
    localparam int LC_IDX_W = 5;

    typedef logic [LC_W-1:0]     lc_cnt_t;
    typedef logic [LC_IDX_W-1:0] lc_idx_t;

    localparam lc_cnt_t LEN_TABLE [32] = '{
        8'd10,  8'd254, 8'd20,  8'd2,
        8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,
        8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,
        8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,
        8'd16,  8'd28,  8'd32,  8'd30
    };

endpackage

// File: rtl/apu_length_counter_if.sv
// Length-counter channel bus: CPU write side, frame tick,
// halt/enable controls and the count/status outputs.
interface apu_length_counter_if
    import apu_pkg::*;
#(
    parameter int CNT_W = LC_W
);
    logic [7:0]       DB;
    logic             LC_WR;
    logic             LC_CLK;
    logic             HALT;
    logic             EN;
    logic [CNT_W-1:0] LC_CNT;
    logic             LC_NZ;

    modport master (
        output DB, LC_WR, LC_CLK, HALT, EN,
        input  LC_CNT, LC_NZ
    );

    modport slave (
        input  DB, LC_WR, LC_CLK, HALT, EN,
        output LC_CNT, LC_NZ
    );
endinterface

// File: rtl/apu_length_counter_pla.sv
// Length decoder PLA: DB[7:3] selects the length-counter load value.
module LengthCounter_PLA
    import apu_pkg::*;
(
    input  logic [7:0]      DB,
    output logic [LC_W-1:0] LC_Out
);
    logic unused_db;
    assign unused_db = ^DB[2:0];

    always_comb begin
        LC_Out = '0;
        unique case (DB[7:3])
            5'd0:  LC_Out = 8'd10;
            5'd1:  LC_Out = 8'd254;
            5'd2:  LC_Out = 8'd20;
            5'd3:  LC_Out = 8'd2;
            5'd4:  LC_Out = 8'd40;
            5'd5:  LC_Out = 8'd4;
            5'd6:  LC_Out = 8'd80;
            5'd7:  LC_Out = 8'd6;
            5'd8:  LC_Out = 8'd160;
            5'd9:  LC_Out = 8'd8;
            5'd10: LC_Out = 8'd60;
            5'd11: LC_Out = 8'd10;
            5'd12: LC_Out = 8'd14;
            5'd13: LC_Out = 8'd12;
            5'd14: LC_Out = 8'd26;
            5'd15: LC_Out = 8'd14;
            5'd16: LC_Out = 8'd12;
            5'd17: LC_Out = 8'd16;
            5'd18: LC_Out = 8'd24;
            5'd19: LC_Out = 8'd18;
            5'd20: LC_Out = 8'd48;
            5'd21: LC_Out = 8'd20;
            5'd22: LC_Out = 8'd96;
            5'd23: LC_Out = 8'd22;
            5'd24: LC_Out = 8'd192;
            5'd25: LC_Out = 8'd24;
            5'd26: LC_Out = 8'd72;
            5'd27: LC_Out = 8'd26;
            5'd28: LC_Out = 8'd16;
            5'd29: LC_Out = 8'd28;
            5'd30: LC_Out = 8'd32;
            5'd31: LC_Out = 8'd30;
            default: LC_Out = '0;
        endcase
    end
endmodule

// File: rtl/apu_length_counter.sv
// Per-channel APU length counter: latched PLA load, half-frame
// decrement with optional halt delay, enable gating.
module apu_length_counter
    import apu_pkg::*;
#(
    parameter int CNT_W      = LC_W,
    parameter int HALT_DELAY = 1
)(
    input  logic                 ACLK,
    input  logic                 nRES,
    apu_length_counter_if.slave  lc
);
    lc_idx_t          idx_q, idx_d;
    logic             ld_q, ld_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             nz_q, nz_d;

    logic [CNT_W-1:0] pla_out;
    logic             eff_halt;
    logic             dec;
    logic             apply;

    LengthCounter_PLA u_pla (
        .DB     ({idx_q, 3'b000}),
        .LC_Out (pla_out)
    );

    always_comb begin
        idx_d  = lc.LC_WR ? lc.DB[7:3] : idx_q;
        ld_d   = lc.LC_WR;
        halt_d = lc.HALT;

        eff_halt = (HALT_DELAY != 0) ? halt_q : lc.HALT;
        dec      = lc.LC_CLK && !eff_halt && (cnt_q != '0);
        // A fresh write supersedes the pending one before it lands
        apply    = ld_q && !lc.LC_WR;

        cnt_d = cnt_q;
        if (!lc.EN)
            cnt_d = '0;
        else if (apply && dec)
            cnt_d = cnt_q - CNT_W'(1);
        else if (apply)
            cnt_d = pla_out;
        else if (dec)
            cnt_d = cnt_q - CNT_W'(1);

        nz_d = (cnt_d != '0);
    end

    always_ff @(posedge ACLK) begin
        if (!nRES) begin
            idx_q  <= '0;
            ld_q   <= 1'b0;
            halt_q <= 1'b0;
            cnt_q  <= '0;
            nz_q   <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            ld_q   <= ld_d;
            halt_q <= halt_d;
            cnt_q  <= cnt_d;
            nz_q   <= nz_d;
        end
    end

    assign lc.LC_CNT = cnt_q;
    assign lc.LC_NZ  = nz_q;
endmodule

// File: tb/tb_apu_length_counter.sv
// Directed bench for apu_length_counter with an expected-value
// queue popped after each observed edge.
module tb_apu_length_counter;
    import apu_pkg::*;

    typedef struct {
        string   tag;
        lc_cnt_t cnt;
        logic    nz;
    } exp_t;

    logic ACLK;
    logic nRES;
    int   n_cmp;
    int   n_fail;
    exp_t sb[$];

    apu_length_counter_if #(.CNT_W(LC_W)) lc ();

    apu_length_counter #(
        .CNT_W      (LC_W),
        .HALT_DELAY (1)
    ) dut (
        .ACLK (ACLK),
        .nRES (nRES),
        .lc   (lc.slave)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic push(input string tag, input lc_cnt_t cnt);
        exp_t e;
        e.tag = tag;
        e.cnt = cnt;
        e.nz  = (cnt != '0);
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        assert (lc.LC_CNT === e.cnt) else begin
            n_fail++;
            $error("FAIL %s cnt: got %0h expected %0h",
                   e.tag, lc.LC_CNT, e.cnt);
        end
        n_cmp++;
        assert (lc.LC_NZ === e.nz) else begin
            n_fail++;
            $error("FAIL %s nz: got %0b expected %0b",
                   e.tag, lc.LC_NZ, e.nz);
        end
    endtask

    task automatic write_idx(input lc_idx_t idx);
        lc.DB    = {idx, 3'b000};
        lc.LC_WR = 1'b1;
        tick();
        lc.LC_WR = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        nRES      = 1'b0;
        lc.DB     = '0;
        lc.LC_WR  = 1'b0;
        lc.LC_CLK = 1'b0;
        lc.HALT   = 1'b0;
        lc.EN     = 1'b1;

        // reset with random bus activity
        repeat (3) begin
            lc.DB     = 8'($urandom);
            lc.LC_WR  = 1'($urandom);
            lc.LC_CLK = 1'($urandom);
            tick();
            push("reset", 8'd0);
            check();
        end
        lc.LC_WR  = 1'b0;
        lc.LC_CLK = 1'b0;
        nRES      = 1'b1;

        // load and count down
        write_idx(5'd1);
        push("load_idx1", 8'hFE);
        check();
        lc.LC_CLK = 1'b1;
        tick();
        push("dec_first", 8'hFD);
        check();
        repeat (253) tick();
        push("dec_to_zero", 8'd0);
        check();
        tick();
        push("no_wrap", 8'd0);
        check();
        lc.LC_CLK = 1'b0;

        // halt, including the one-cycle halt delay
        write_idx(5'd3);
        push("load_idx3", 8'h02);
        check();
        lc.HALT = 1'b1;
        tick();
        lc.LC_CLK = 1'b1;
        repeat (5) tick();
        push("halted", 8'h02);
        check();
        lc.HALT = 1'b0;
        tick();
        push("halt_delay", 8'h02);
        check();
        tick();
        push("unhalt_dec", 8'h01);
        check();
        lc.LC_CLK = 1'b0;

        // disable
        write_idx(5'd1);
        push("reload_fe", 8'hFE);
        check();
        lc.EN = 1'b0;
        tick();
        push("disable", 8'd0);
        check();
        write_idx(5'd1);
        push("load_disabled", 8'd0);
        check();
        lc.EN = 1'b1;
        tick();
        push("reenable", 8'd0);
        check();

        // reset mid-count
        write_idx(5'd1);
        nRES = 1'b0;
        tick();
        push("reset_mid", 8'd0);
        check();
        nRES = 1'b1;

        // conflict: nonzero count, decrement wins
        write_idx(5'd7);
        lc.LC_CLK = 1'b1;
        tick();
        push("pre_conflict", 8'h05);
        check();
        lc.LC_CLK = 1'b0;
        lc.DB     = 8'h08;
        lc.LC_WR  = 1'b1;
        tick();
        lc.LC_WR  = 1'b0;
        lc.LC_CLK = 1'b1;
        tick();
        push("conflict_dec", 8'h04);
        check();
        lc.LC_CLK = 1'b0;

        // conflict: zero count, load wins
        lc.EN = 1'b0;
        tick();
        lc.EN = 1'b1;
        lc.DB    = 8'h08;
        lc.LC_WR = 1'b1;
        tick();
        lc.LC_WR  = 1'b0;
        lc.LC_CLK = 1'b1;
        tick();
        push("conflict_zero", 8'hFE);
        check();
        lc.LC_CLK = 1'b0;

        // conflict under halt: load wins
        lc.HALT = 1'b1;
        tick();
        lc.DB    = 8'h18;
        lc.LC_WR = 1'b1;
        tick();
        lc.LC_WR  = 1'b0;
        lc.LC_CLK = 1'b1;
        tick();
        push("conflict_halt", 8'h02);
        check();
        lc.LC_CLK = 1'b0;
        lc.HALT   = 1'b0;
        tick();

        // back-to-back writes: last one wins
        lc.DB    = 8'h08;
        lc.LC_WR = 1'b1;
        tick();
        lc.DB = 8'h38;
        tick();
        push("rewrite_hold", 8'h02);
        check();
        lc.LC_WR = 1'b0;
        tick();
        push("last_write", 8'h06);
        check();

        // full table sweep
        for (int i = 0; i < 32; i++) begin
            write_idx(lc_idx_t'(i));
            push($sformatf("sweep_%0d", i), LEN_TABLE[i]);
            check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end
endmodule
